ide_mcu_spi: RTL and testbench

- MCU-facing end of the IDE emulation: an SPI slave through which the MCU services commands the FPGA taskfile has flagged with bsy/mcu_irq.
- MCU can read taskfile registers, stream the 512-byte sector buffer out or in through the sector RAM's second port, write the error register, and signal command completion.
- Sits beside the host taskfile block; shares its SB_RAM256x16 sector buffer and status/error registers.

---
 rtl/ide_pkg.sv | 45 ++++
 rtl/ide_mcu_spi_if.sv | 36 +++
 rtl/ide_spi_shifter.sv | 91 +++++++++
 rtl/ide_mcu_spi.sv | 132 +++++++++++++
 tb/tb_ide_mcu_spi.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ide_pkg.sv
// ----------------------------------------------------------------------------
// Module : ide_pkg
// Brief  : Shared opcodes, FSM states and taskfile byte indices for the
//          MCU-side SPI command channel of the IDE emulation.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
`default_nettype none

package ide_pkg;

  localparam logic [7:0] OP_RDREG = 8'h00;
  localparam logic [7:0] OP_RDBUF = 8'h10;
  localparam logic [7:0] OP_WRBUF = 8'h20;
  localparam logic [7:0] OP_WRERR = 8'h30;
  localparam logic [7:0] OP_DONE  = 8'h40;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_OPCODE = 2'd1,
    ST_DATA   = 2'd2,
    ST_IGNORE = 2'd3
  } state_t;

  localparam int TF_STATUS   = 0;
  localparam int TF_COMMAND  = 1;
  localparam int TF_FEATURES = 2;
  localparam int TF_SECCOUNT = 3;
  localparam int TF_LBA0     = 4;
  localparam int TF_LBA1     = 5;
  localparam int TF_LBA2     = 6;
  localparam int TF_LBA3     = 7;

  // Register reads occupy the whole 8'h00-07 block.
  function automatic logic is_rdreg(input logic [7:0] b);
    return b[7:3] == OP_RDREG[7:3];
  endfunction

  function automatic logic op_known(input logic [7:0] b);
    return is_rdreg(b) || (b == OP_RDBUF) || (b == OP_WRBUF) ||
           (b == OP_WRERR) || (b == OP_DONE);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ide_mcu_spi_if.sv
// ----------------------------------------------------------------------------
// Module : ide_mcu_spi_if
// Brief  : SPI pins, sector-RAM port and taskfile strobes of the MCU channel.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
`default_nettype none

interface ide_mcu_spi_if;
  logic        mcu_ss_n;
  logic        mcu_sclk;
  logic        mcu_mosi;
  logic        mcu_miso;
  logic [63:0] tf_regs;
  logic [7:0]  ram_a;
  logic [15:0] ram_rdata;
  logic [15:0] ram_wdata;
  logic        ram_we;
  logic        err_wr;
  logic [7:0]  err_data;
  logic        done_strobe;
  logic        done_drq;

  modport slave (
    input  mcu_ss_n, mcu_sclk, mcu_mosi, tf_regs, ram_rdata,
    output mcu_miso, ram_a, ram_wdata, ram_we, err_wr, err_data,
           done_strobe, done_drq
  );

  modport master (
    output mcu_ss_n, mcu_sclk, mcu_mosi, tf_regs, ram_rdata,
    input  mcu_miso, ram_a, ram_wdata, ram_we, err_wr, err_data,
           done_strobe, done_drq
  );
endinterface

`default_nettype wire

// File: rtl/ide_spi_shifter.sv
// ----------------------------------------------------------------------------
// Module : ide_spi_shifter
// Brief  : Mode-0 SPI slave bit engine: synchronisers, sclk edge detect,
//          rx/tx shift registers and byte framing.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
`default_nettype none

module ide_spi_shifter #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] IDLE_MISO   = 8'h00
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ss_n_in,
  input  logic       sclk_in,
  input  logic       mosi_in,
  input  logic [7:0] tx_byte,
  output logic       ss_n,
  output logic       miso,
  output logic       byte_done,
  output logic       tx_load,
  output logic [7:0] rx_byte
);

  logic [SYNC_STAGES-1:0] r_ss_sync, r_sclk_sync, r_mosi_sync;
  logic       r_sclk_prev;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_rx_sh, r_rx_byte, r_tx_sh;
  logic       r_byte_done, r_tx_pending;
  logic       w_sclk, w_mosi, w_rise, w_fall;

  assign ss_n   = r_ss_sync[SYNC_STAGES-1];
  assign w_sclk = r_sclk_sync[SYNC_STAGES-1];
  assign w_mosi = r_mosi_sync[SYNC_STAGES-1];
  assign w_rise = w_sclk & ~r_sclk_prev;
  assign w_fall = ~w_sclk & r_sclk_prev;

  assign miso      = ~ss_n & r_tx_sh[7];
  assign byte_done = r_byte_done;
  assign rx_byte   = r_rx_byte;
  assign tx_load   = w_fall & r_tx_pending & ~ss_n;

  // ss_n resets low so a select held across reset is not mistaken for a fresh one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ss_sync    <= '0;
      r_sclk_sync  <= '0;
      r_mosi_sync  <= '0;
      r_sclk_prev  <= 1'b0;
      r_bit_cnt    <= 3'd0;
      r_rx_sh      <= 8'h00;
      r_rx_byte    <= 8'h00;
      r_byte_done  <= 1'b0;
      r_tx_sh      <= 8'h00;
      r_tx_pending <= 1'b0;
    end else begin
      r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], ss_n_in};
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk_in};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi_in};
      r_sclk_prev <= w_sclk;
      r_byte_done <= w_rise && (r_bit_cnt == 3'd7);

      if (w_rise) begin
        r_rx_sh <= {r_rx_sh[6:0], w_mosi};
        if (r_bit_cnt == 3'd7) r_rx_byte <= {r_rx_sh[6:0], w_mosi};
      end

      if (ss_n) r_bit_cnt <= 3'd0;
      else if (w_rise) r_bit_cnt <= r_bit_cnt + 3'd1;

      if (ss_n) begin
        r_tx_sh      <= IDLE_MISO;
        r_tx_pending <= 1'b0;
      end else begin
        if (r_byte_done) r_tx_pending <= 1'b1;
        if (w_fall) begin
          if (r_tx_pending) begin
            r_tx_sh      <= tx_byte;
            r_tx_pending <= 1'b0;
          end else begin
            r_tx_sh <= {r_tx_sh[6:0], 1'b0};
          end
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/ide_mcu_spi.sv
// ----------------------------------------------------------------------------
// Module : ide_mcu_spi
// Brief  : MCU SPI command slave: taskfile reads, sector-buffer streaming,
//          error register write and command completion strobes.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
`default_nettype none

module ide_mcu_spi
  import ide_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] IDLE_MISO   = 8'h00
) (
  input  logic         clk,
  input  logic         reset_n,
  ide_mcu_spi_if.slave bus
);

  logic        w_ss_n, w_byte_done, w_tx_load;
  logic [7:0]  w_rx_byte, w_tx_byte;
  state_t      r_state, w_state_next;
  logic        r_armed, r_first, r_odd, r_reg_valid;
  logic [7:0]  r_op, r_reg_byte, r_ram_a, r_err_data;
  logic [15:0] r_ram_wdata;
  logic        r_ram_we, r_err_wr, r_done_strobe, r_done_drq;

  ide_spi_shifter #(
    .SYNC_STAGES (SYNC_STAGES),
    .IDLE_MISO   (IDLE_MISO)
  ) u_shifter (
    .clk       (clk),
    .reset_n   (reset_n),
    .ss_n_in   (bus.mcu_ss_n),
    .sclk_in   (bus.mcu_sclk),
    .mosi_in   (bus.mcu_mosi),
    .tx_byte   (w_tx_byte),
    .ss_n      (w_ss_n),
    .miso      (bus.mcu_miso),
    .byte_done (w_byte_done),
    .tx_load   (w_tx_load),
    .rx_byte   (w_rx_byte)
  );

  assign bus.ram_a       = r_ram_a;
  assign bus.ram_wdata   = r_ram_wdata;
  assign bus.ram_we      = r_ram_we;
  assign bus.err_wr      = r_err_wr;
  assign bus.err_data    = r_err_data;
  assign bus.done_strobe = r_done_strobe;
  assign bus.done_drq    = r_done_drq;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_tx_byte    = IDLE_MISO;
    case (r_state)
      ST_IDLE:   if (!w_ss_n && r_armed) w_state_next = ST_OPCODE;
      ST_OPCODE: if (w_byte_done) w_state_next = op_known(w_rx_byte) ? ST_DATA : ST_IGNORE;
      ST_DATA: begin
        if (is_rdreg(r_op) && r_reg_valid) w_tx_byte = r_reg_byte;
        else if (r_op == OP_RDBUF)         w_tx_byte = r_odd ? bus.ram_rdata[15:8] : bus.ram_rdata[7:0];
      end
      default: ;
    endcase
    if (w_ss_n) w_state_next = ST_IDLE;
  end

  // A byte finishing in the deselect cycle is still acted on here; the FSM drops to IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_armed       <= 1'b0;
      r_first       <= 1'b0;
      r_odd         <= 1'b0;
      r_reg_valid   <= 1'b0;
      r_op          <= 8'h00;
      r_reg_byte    <= 8'h00;
      r_ram_a       <= 8'h00;
      r_ram_wdata   <= 16'h0000;
      r_ram_we      <= 1'b0;
      r_err_wr      <= 1'b0;
      r_err_data    <= 8'h00;
      r_done_strobe <= 1'b0;
      r_done_drq    <= 1'b0;
    end else begin
      r_ram_we      <= 1'b0;
      r_err_wr      <= 1'b0;
      r_done_strobe <= 1'b0;
      if (w_ss_n)    r_armed     <= 1'b1;
      if (r_ram_we)  r_ram_a     <= r_ram_a + 8'd1;
      if (w_tx_load) r_reg_valid <= 1'b0;

      if (w_byte_done) begin
        if (r_state == ST_OPCODE) begin
          r_op        <= w_rx_byte;
          r_odd       <= 1'b0;
          r_first     <= 1'b1;
          r_reg_valid <= is_rdreg(w_rx_byte);
          r_reg_byte  <= bus.tf_regs[{w_rx_byte[2:0], 3'b000} +: 8];
          if (w_rx_byte == OP_RDBUF || w_rx_byte == OP_WRBUF) r_ram_a <= 8'h00;
        end else if (r_state == ST_DATA) begin
          r_first <= 1'b0;
          if (r_op == OP_RDBUF) begin
            r_odd <= ~r_odd;
            if (r_odd) r_ram_a <= r_ram_a + 8'd1;
          end else if (r_op == OP_WRBUF) begin
            r_odd <= ~r_odd;
            if (r_odd) begin
              r_ram_wdata[15:8] <= w_rx_byte;
              r_ram_we          <= 1'b1;
            end else begin
              r_ram_wdata[7:0]  <= w_rx_byte;
            end
          end else if (r_op == OP_WRERR && r_first) begin
            r_err_data <= w_rx_byte;
            r_err_wr   <= 1'b1;
          end else if (r_op == OP_DONE && r_first) begin
            r_done_drq    <= w_rx_byte[0];
            r_done_strobe <= 1'b1;
          end
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ide_mcu_spi.sv
// ----------------------------------------------------------------------------
// Module : tb_ide_mcu_spi
// Brief  : Self-checking bench for ide_mcu_spi with a behavioural MCU model.
// Rev    : 1.0  initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_ide_mcu_spi;
  import ide_pkg::*;

  localparam logic [7:0] IDLE = 8'h00;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [63:0] tf_val = 64'h0;

  ide_mcu_spi_if bus();

  ide_mcu_spi #(.SYNC_STAGES(2), .IDLE_MISO(IDLE)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  assign bus.tf_regs = tf_val;

  // Sector RAM with one-clock read latency and a bench-side preload port.
  logic [15:0] ram [256];
  logic        pre_en = 1'b0;
  logic [7:0]  pre_a  = 8'h00;
  logic [15:0] pre_d  = 16'h0;
  always @(posedge clk) begin
    bus.ram_rdata <= ram[bus.ram_a];
    if (pre_en) ram[pre_a] <= pre_d;
    else if (bus.ram_we) ram[bus.ram_a] <= bus.ram_wdata;
  end

  int we_cnt = 0, err_cnt = 0, done_cnt = 0, multi_cnt = 0;
  logic [7:0] last_err = 8'h00;
  logic       last_drq = 1'b0;
  always @(negedge clk) begin
    if (bus.ram_we) we_cnt++;
    if (bus.err_wr) begin err_cnt++; last_err = bus.err_data; end
    if (bus.done_strobe) begin done_cnt++; last_drq = bus.done_drq; end
    if ((32'(bus.ram_we) + 32'(bus.err_wr) + 32'(bus.done_strobe)) > 1) multi_cnt++;
  end

  int n_tests = 0, n_fail = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [7:0]  txb [600];
  logic [7:0]  rxb [600];
  logic [15:0] exp_mem [256];

  // Expected MISO byte at position idx of a transaction opened with op.
  function automatic logic [7:0] model_miso(input logic [7:0] op, input int idx);
    logic [15:0] w;
    if (idx == 0) return IDLE;
    if (op < 8'h08) return (idx == 1) ? tf_val[op*8 +: 8] : IDLE;
    if (op == 8'h10) begin
      w = exp_mem[((idx - 1) / 2) % 256];
      return ((idx - 1) % 2) ? w[15:8] : w[7:0];
    end
    return IDLE;
  endfunction

  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i >= 8 - n; i--) begin
      bus.mcu_mosi = tx[i];
      #40;
      rx[i] = bus.mcu_miso;
      bus.mcu_sclk = 1'b1;
      #40;
      bus.mcu_sclk = 1'b0;
    end
  endtask

  task automatic sel();
    bus.mcu_ss_n = 1'b0;
    #40;
  endtask

  task automatic desel();
    #40;
    bus.mcu_ss_n = 1'b1;
    #80;
  endtask

  task automatic xact(input int n);
    logic [7:0] r;
    sel();
    for (int i = 0; i < n; i++) begin
      spi_bits(txb[i], 8, r);
      rxb[i] = r;
    end
    desel();
  endtask

  initial begin
    int k, d0, e0, w0;
    logic [7:0] r;
    bus.mcu_ss_n = 1'b1;
    bus.mcu_sclk = 1'b0;
    bus.mcu_mosi = 1'b0;
    #52;
    check("rst_miso", 32'(bus.mcu_miso), 0);
    check("rst_ram_a", 32'(bus.ram_a), 0);
    check("rst_wdata", 32'(bus.ram_wdata), 0);
    check("rst_we", 32'(bus.ram_we), 0);
    check("rst_err_wr", 32'(bus.err_wr), 0);
    check("rst_err_data", 32'(bus.err_data), 0);
    check("rst_done", 32'(bus.done_strobe), 0);
    check("rst_drq", 32'(bus.done_drq), 0);
    reset_n = 1'b1;
    #60;

    // Register reads: seccount with a fixed value, then every index randomly.
    tf_val = {$urandom, $urandom};
    tf_val[TF_SECCOUNT*8 +: 8] = 8'h5a;
    txb[0] = 8'h03; txb[1] = 8'h00;
    xact(2);
    check("rdreg_op_byte", 32'(rxb[0]), 32'(IDLE));
    check("rdreg_5a", 32'(rxb[1]), 32'h5a);
    for (int i = 0; i < 8; i++) begin
      tf_val = {$urandom, $urandom};
      txb[0] = 8'(i);
      txb[1] = 8'($urandom);
      txb[2] = 8'($urandom);
      xact(3);
      for (int j = 0; j < 3; j++) check($sformatf("rdreg%0d_b%0d", i, j), 32'(rxb[j]), 32'(model_miso(8'(i), j)));
    end

    // Fixed write stream.
    w0 = we_cnt;
    txb[0] = 8'h20; txb[1] = 8'h11; txb[2] = 8'h22; txb[3] = 8'h33; txb[4] = 8'h44;
    xact(5);
    check("wr_we_cnt", 32'(we_cnt - w0), 2);
    check("wr_word0", 32'(ram[0]), 32'h2211);
    check("wr_word1", 32'(ram[1]), 32'h4433);
    check("wr_ram_a", 32'(bus.ram_a), 2);

    // Random-length write stream; an odd trailing byte must not write.
    for (int t = 0; t < 3; t++) begin
      k = $urandom_range(2, 40);
      w0 = we_cnt;
      txb[0] = 8'h20;
      for (int i = 1; i <= k; i++) txb[i] = 8'($urandom);
      xact(k + 1);
      check("wrr_we_cnt", 32'(we_cnt - w0), 32'(k / 2));
      for (int j = 0; j < k / 2; j++) check($sformatf("wrr_word%0d", j), 32'(ram[j]), {16'h0, txb[2*j+2], txb[2*j+1]});
      check("wrr_ram_a", 32'(bus.ram_a), 32'(k / 2));
    end

    // Abort inside the second data byte.
    w0 = we_cnt;
    sel();
    spi_bits(8'h20, 8, r);
    spi_bits(8'hab, 8, r);
    spi_bits(8'hcd, 4, r);
    desel();
    check("abort_no_we", 32'(we_cnt - w0), 0);
    txb[0] = 8'h00; txb[1] = 8'h00;
    xact(2);
    check("abort_next_rdreg", 32'(rxb[1]), 32'(tf_val[7:0]));

    // Completion and error writes; trailing bytes ignored.
    d0 = done_cnt;
    txb[0] = 8'h40; txb[1] = 8'h01; txb[2] = 8'h00;
    xact(3);
    check("done_cnt1", 32'(done_cnt - d0), 1);
    check("done_drq1", 32'(last_drq), 1);
    d0 = done_cnt;
    txb[0] = 8'h40; txb[1] = 8'h00; txb[2] = 8'hff;
    xact(3);
    check("done_cnt0", 32'(done_cnt - d0), 1);
    check("done_drq0", 32'(last_drq), 0);
    e0 = err_cnt;
    txb[0] = 8'h30; txb[1] = 8'h04; txb[2] = 8'h77;
    xact(3);
    check("err_cnt", 32'(err_cnt - e0), 1);
    check("err_data", 32'(last_err), 32'h04);

    // Unknown opcode.
    d0 = done_cnt; e0 = err_cnt; w0 = we_cnt;
    txb[0] = 8'h55;
    for (int i = 1; i < 4; i++) txb[i] = 8'($urandom);
    xact(4);
    for (int j = 0; j < 4; j++) check($sformatf("unk_b%0d", j), 32'(rxb[j]), 32'(IDLE));
    check("unk_strobes", 32'((done_cnt - d0) + (err_cnt - e0) + (we_cnt - w0)), 0);

    // Read stream across the wrap.
    pre_en = 1'b1;
    for (int i = 0; i < 256; i++) begin
      exp_mem[i] = 16'($urandom);
      pre_a = 8'(i);
      pre_d = exp_mem[i];
      #10;
    end
    pre_en = 1'b0;
    txb[0] = 8'h10;
    for (int i = 1; i <= 514; i++) txb[i] = 8'($urandom);
    xact(515);
    for (int i = 0; i <= 514; i++) check($sformatf("rdbuf_b%0d", i), 32'(rxb[i]), 32'(model_miso(8'h10, i)));

    // Reset in the middle of a read stream, select still held across it.
    sel();
    spi_bits(8'h10, 8, r);
    spi_bits(8'h00, 8, r);
    spi_bits(8'h00, 3, r);
    #20;
    reset_n = 1'b0;
    #20;
    check("mid_rst_miso", 32'(bus.mcu_miso), 0);
    check("mid_rst_ram_a", 32'(bus.ram_a), 0);
    check("mid_rst_strobes", 32'({bus.ram_we, bus.err_wr, bus.done_strobe}), 0);
    reset_n = 1'b1;
    #40;
    d0 = done_cnt;
    spi_bits(8'h40, 8, r);
    spi_bits(8'h01, 8, r);
    #40;
    check("unarmed_no_done", 32'(done_cnt - d0), 0);
    desel();
    txb[0] = 8'h40; txb[1] = 8'h01;
    xact(2);
    check("rearmed_done", 32'(done_cnt - d0), 1);
    txb[0] = 8'h07; txb[1] = 8'h00;
    xact(2);
    check("post_rst_rdreg", 32'(rxb[1]), 32'(tf_val[63:56]));

    check("strobe_overlap", 32'(multi_cnt), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
